fp_addsub_seq: RTL and testbench
================================

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning stored fraction width (hidden bit excluded).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  request; sampled only while busy=0.
REQ-006 Port op  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 Port a  input  1+EXP_W+MAN_W  operand A, {sign, exponent, fraction}; sampled with start.
REQ-008 Port b  input  1+EXP_W+MAN_W  operand B, same format; sampled with start.
REQ-009 Port busy  output  1  high from the edge accepting start until the edge asserting done.
REQ-010 Port done  output  1  one-cycle pulse: result and flags valid.
REQ-011 Port result  output  1+EXP_W+MAN_W  packed sum/difference; held until the next accepted start.
REQ-012 Port overflow  output  1  result exponent saturated to all-ones.
REQ-013 Port underflow  output  1  result flushed to zero by exponent underflow.

Function
REQ-014 FSM states IDLE, ALIGN, ADD, NORM; start with busy=0 SHALL capture operands and go IDLE->ALIGN; start while busy=1 SHALL be ignored.
REQ-015 At capture, op=1 SHALL invert b's sign; operands SHALL be ordered so the larger magnitude (exponent, then fraction) is the big operand; equal magnitudes keep a as big.
REQ-016 Operands with exponent 0 SHALL be treated as zero (denormals flushed); hidden bit = 1 otherwise.
REQ-017 Datapath mantissas SHALL be MAN_W+2 bits (carry, hidden, fraction); bits shifted out SHALL be discarded (truncation toward zero).
REQ-018 ALIGN SHALL shift the small mantissa right one bit per cycle, d = min(exp_big - exp_small, MAN_W+2) shifts, then go to ADD on the following edge (d+1 cycles in ALIGN).
REQ-019 ADD (1 cycle) SHALL add mantissas if signs equal, else subtract small from big; result sign = sign of big operand.
REQ-020 NORM SHALL, per cycle: if carry bit set, shift right 1 and increment exponent; else if mantissa nonzero and hidden bit 0, shift left 1 and decrement exponent; else finish; n = number of shifts.
REQ-021 NORM's finishing edge SHALL write result, overflow, underflow, pulse done, clear busy and return to IDLE.
REQ-022 Latency SHALL be d+n+3 cycles from the start-sampling edge to the edge raising done; max 2*MAN_W+7.
REQ-023 Zero mantissa sum SHALL give result +0 (all bits 0), flags 0, n=0.
REQ-024 Exponent reaching all-ones SHALL give result {sign, all-ones, 0}, overflow=1, and end NORM that edge.
REQ-025 Exponent decrementing below 1 SHALL give result {sign, 0, 0}, underflow=1, and end NORM that edge.
REQ-026 Input with exponent all-ones SHALL be passed through unchanged (a has priority, b's sign post-op), d=0, n=0, flags 0.
REQ-027 Flags SHALL clear at each accepted start.
REQ-028 start may be asserted on the same edge done is asserted' successor cycle; back-to-back operations SHALL need no idle cycle beyond done.

Reset
REQ-029 rst=1 SHALL force IDLE, busy=0, done=0, result=0, overflow=0, underflow=0 at the next edge, aborting any operation in progress; no done pulse for the aborted operation.
REQ-030 rst SHALL have priority over start on the same edge.

Verification
REQ-031 a=0x3F800000, b=0x3F800000, op=0 -> result 0x40000000, flags 0, done 4 cycles after start.
REQ-032 a=0x40400000, b=0xBF800000, op=0 -> result 0x40000000, done 4 cycles after start (d=1, n=0).
REQ-033 a=0x3FC00000, b=0x3FC00000, op=1 -> result 0x00000000, flags 0, done 3 cycles after start.
REQ-034 a=0x7F7FFFFF, b=0x7F7FFFFF, op=0 -> result 0x7F800000, overflow=1, underflow=0.
REQ-035 start a=0x3F800000,b=0x3F800000, rst pulsed 2 cycles later -> busy=0, result=0, no done; new start then completes normally; start pulses while busy have no effect.
REQ-036 a=0x00800000, b=0x80800001... replaced by a=0x00C00000, b=0x00800000, op=1 -> underflow=1, result 0x00000000 after normalisation attempts below exponent 1.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// Sequential floating-point adder/subtractor: operands are captured, aligned one
// bit per cycle, added in one cycle and normalised one bit per cycle.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int FW = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 2;
  localparam int CW = $clog2(MW + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_PRE = EXP_MAX - EXP_ONE;
  localparam logic [CW-1:0]    D_MAX   = CW'(MW);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

  state_t state, state_next;

  logic             big_sign, small_sign;
  logic [EXP_W-1:0] big_exp;
  logic [MW-1:0]    big_mant, small_mant;
  logic [CW-1:0]    shift_cnt;
  logic             special;
  logic [FW-1:0]    special_res;

  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic [MW-1:0]    a_mant, b_mant;
  logic             a_is_big, a_spec, b_spec;
  logic [EXP_W-1:0] exp_diff;
  logic [CW-1:0]    cap_d;
  logic [FW-1:0]    cap_spec_res;

  assign a_sign = a[FW-1];
  assign b_sign = b[FW-1] ^ op;
  assign a_exp  = a[FW-2 -: EXP_W];
  assign b_exp  = b[FW-2 -: EXP_W];
  assign a_frac = a[MAN_W-1:0];
  assign b_frac = b[MAN_W-1:0];

  // Zero exponent means zero here: denormal fractions are dropped entirely
  assign a_mant   = (a_exp == '0) ? '0 : {2'b01, a_frac};
  assign b_mant   = (b_exp == '0) ? '0 : {2'b01, b_frac};
  assign a_is_big = {a_exp, a_frac} >= {b_exp, b_frac};
  assign a_spec   = &a_exp;
  assign b_spec   = &b_exp;
  assign exp_diff = a_is_big ? (a_exp - b_exp) : (b_exp - a_exp);
  assign cap_spec_res = a_spec ? a : {b_sign, b[FW-2:0]};

  always_comb begin
    cap_d = CW'(exp_diff);
    if (int'(exp_diff) > MW)
      cap_d = D_MAX;
    if (a_spec || b_spec)
      cap_d = '0;
  end

  logic          norm_finish, norm_ovf, norm_unf, norm_shr, norm_shl;
  logic [FW-1:0] norm_res;

  // One normalisation decision per cycle; saturation and flush end the operation at once
  always_comb begin
    norm_finish = 1'b0;
    norm_ovf    = 1'b0;
    norm_unf    = 1'b0;
    norm_shr    = 1'b0;
    norm_shl    = 1'b0;
    norm_res    = {big_sign, big_exp, big_mant[MAN_W-1:0]};
    if (special) begin
      norm_finish = 1'b1;
      norm_res    = special_res;
    end else if (big_mant == '0) begin
      norm_finish = 1'b1;
      norm_res    = '0;
    end else if (big_mant[MW-1]) begin
      if (big_exp == EXP_PRE) begin
        norm_finish = 1'b1;
        norm_ovf    = 1'b1;
        norm_res    = {big_sign, EXP_MAX, {MAN_W{1'b0}}};
      end else begin
        norm_shr = 1'b1;
      end
    end else if (!big_mant[MW-2]) begin
      if (big_exp <= EXP_ONE) begin
        norm_finish = 1'b1;
        norm_unf    = 1'b1;
        norm_res    = {big_sign, {(FW-1){1'b0}}};
      end else begin
        norm_shl = 1'b1;
      end
    end else begin
      norm_finish = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = ALIGN;
      ALIGN: if (shift_cnt == '0) state_next = ADD;
      ADD:   state_next = NORM;
      NORM:  if (norm_finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath registers; the operand with the larger magnitude always sits in big_*
  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      big_sign    <= 1'b0;
      small_sign  <= 1'b0;
      big_exp     <= '0;
      big_mant    <= '0;
      small_mant  <= '0;
      shift_cnt   <= '0;
      special     <= 1'b0;
      special_res <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            big_sign    <= a_is_big ? a_sign : b_sign;
            small_sign  <= a_is_big ? b_sign : a_sign;
            big_exp     <= a_is_big ? a_exp  : b_exp;
            big_mant    <= a_is_big ? a_mant : b_mant;
            small_mant  <= a_is_big ? b_mant : a_mant;
            shift_cnt   <= cap_d;
            special     <= a_spec | b_spec;
            special_res <= cap_spec_res;
          end
        end
        ALIGN: begin
          if (shift_cnt != '0) begin
            small_mant <= small_mant >> 1;
            shift_cnt  <= shift_cnt - CNT_ONE;
          end
        end
        ADD: begin
          if (big_sign == small_sign)
            big_mant <= big_mant + small_mant;
          else
            big_mant <= big_mant - small_mant;
        end
        NORM: begin
          if (norm_finish) begin
            result    <= norm_res;
            overflow  <= norm_ovf;
            underflow <= norm_unf;
            done      <= 1'b1;
          end else if (norm_shr) begin
            big_mant <= big_mant >> 1;
            big_exp  <= big_exp + EXP_ONE;
          end else if (norm_shl) begin
            big_mant <= big_mant << 1;
            big_exp  <= big_exp - EXP_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed testbench for fp_addsub_seq with single-precision vectors and
// hand-computed results, flags and latencies.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [31:0] a, b;
  logic        busy, done, overflow, underflow;
  logic [31:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, obs, expv);
      $error("[TB] check %s", tag);
    end
  endtask

  // Pulses start, optionally re-pulses it with junk operands while busy, waits for done
  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                               input int noise, output int lat, output logic seen);
    a = va; b = vb; op = vop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'h1);
    checkOutput("flags_clear", {30'b0, overflow, underflow}, 32'h0);
    checkOutput("done_low_after_start", 32'(done), 32'h0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      if (lat < noise) begin
        start = 1'b1; a = 32'h40400000; b = 32'h40400000; op = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    checkOutput("done_timeout", 32'(seen), 32'h1);
    checkOutput("busy_at_done", 32'(busy), 32'h0);
  endtask

  task automatic runCase(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vop, input logic [31:0] exp_res, input logic exp_ovf,
                         input logic exp_unf, input int exp_lat, input int noise);
    int   lat;
    logic seen;
    applyStimulus(va, vb, vop, noise, lat, seen);
    checkOutput({tag, "_result"}, result, exp_res);
    checkOutput({tag, "_flags"}, {30'b0, overflow, underflow}, {30'b0, exp_ovf, exp_unf});
    if (exp_lat >= 0)
      checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic seen_done;

    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_flags", {30'b0, overflow, underflow}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    runCase("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4, 0);
    runCase("three_minus_one",32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4, 0);
    runCase("cancel_to_zero", 32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b0, 3, 0);
    runCase("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, -1, 0);
    runCase("underflow",      32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 3, 0);
    runCase("left_norm",      32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 1'b0, 1'b0, 6, 0);
    runCase("a_inf",          32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0, 3, 0);
    runCase("b_inf_sub",      32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0, 3, 0);
    runCase("swap_order",     32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 1'b0, 1'b0, 4, 0);
    runCase("zero_plus_one",  32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 28, 0);
    runCase("lsb_survives",   32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 1'b0, 1'b0, 26, 0);
    runCase("lsb_truncated",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 27, 0);
    runCase("carry_truncate", 32'h3F800001, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4, 0);
    runCase("neg_cancel",     32'hBFC00000, 32'h3FC00000, 1'b0, 32'h00000000, 1'b0, 1'b0, 3, 0);
    runCase("denorm_flush",   32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 28, 0);

    // Abort an operation with reset two cycles after start
    a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen_done = 1'b0;
    @(posedge clk); #1;
    seen_done |= done;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_result", result, 32'h0);
    checkOutput("abort_flags", {30'b0, overflow, underflow}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      seen_done |= done;
      @(posedge clk); #1;
    end
    seen_done |= done;
    checkOutput("abort_no_done", 32'(seen_done), 32'h0);

    // Reset wins over a simultaneous start
    a = 32'h40400000; b = 32'h3F800000; op = 1'b0; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    checkOutput("rst_priority_busy", 32'(busy), 32'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen_done |= done;
    end
    checkOutput("rst_priority_no_done", 32'(seen_done), 32'h0);

    runCase("after_abort",    32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4, 0);
    runCase("start_ignored",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
